intr_ctrl: RTL and testbench

//   Multi-source interrupt controller in front of the sc_interrupt CPU core.

---
 rtl/intr_if.sv | 26 ++
 rtl/intr_ctrl.sv | 126 ++++++++++++
 tb/tb_intr_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/intr_if.sv
// Request/acknowledge bundle between the interrupt controller and its CPU-side driver.
interface intr_if #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
);
  logic [NSRC-1:0] irq;
  logic            ien_we;
  logic [NSRC-1:0] ien_wdata;
  logic [NSRC-1:0] ien;
  logic [NSRC-1:0] pending;
  logic            intr;
  logic            inta;
  logic            eoi;
  logic [IDW-1:0]  irq_id;
  logic            busy;

  modport master (
    output irq, ien_we, ien_wdata, inta, eoi,
    input  ien, pending, intr, irq_id, busy
  );

  modport slave (
    input  irq, ien_we, ien_wdata, inta, eoi,
    output ien, pending, intr, irq_id, busy
  );
endinterface

// File: rtl/intr_ctrl.sv
// Edge-capturing, maskable interrupt controller with fixed or round-robin arbitration
// and a single-level intr/inta/eoi handshake towards the CPU.
module intr_ctrl #(
  parameter int NSRC = 4,
  parameter int IDW  = 2,
  parameter int RR   = 0
) (
  input  logic  clk,
  input  logic  clrn,
  intr_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] ien_q, ien_d;
  logic            intr_q, intr_d;
  logic            busy_q, busy_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  lo_win, hi_win, win;
  logic            lo_found, hi_found;
  int              start;

  assign elig  = pend_q & ien_q;
  assign start = (RR != 0) ? int'(ptr_q) : 0;

  // Downward scan keeps the lowest eligible index overall and the lowest at or above start;
  // the latter wins when present, giving wrap-around search from the pointer.
  always_comb begin
    lo_win   = '0;
    hi_win   = '0;
    lo_found = 1'b0;
    hi_found = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_win   = IDW'(i);
        lo_found = 1'b1;
        if (i >= start) begin
          hi_win   = IDW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    busy_d  = busy_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (lo_found) begin
          state_d = S_REQ;
          intr_d  = 1'b1;
          id_d    = win;
        end
      end
      S_REQ: begin
        if (bus.inta) begin
          state_d = S_SVC;
          intr_d  = 1'b0;
          busy_d  = 1'b1;
          clr     = {{(NSRC-1){1'b0}}, 1'b1} << id_q;
        end
      end
      S_SVC: begin
        if (bus.eoi) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (RR != 0) begin
            ptr_d = (id_q == IDW'(NSRC - 1)) ? '0 : id_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        intr_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // A fresh edge on the line being acknowledged must survive the clear.
    pend_d = (pend_q & ~clr) | (bus.irq & ~irq_q);
    ien_d  = bus.ien_we ? bus.ien_wdata : ien_q;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      ien_q   <= '1;
      intr_q  <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= bus.irq;
      pend_q  <= pend_d;
      ien_q   <= ien_d;
      intr_q  <= intr_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.ien     = ien_q;
  assign bus.pending = pend_q;
  assign bus.intr    = intr_q;
  assign bus.irq_id  = id_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed vector table on the fixed-priority instance, directed
// round-robin and reset-in-service sequences, then random traffic against a reference model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [3:0] irq;
  logic       ien_we;
  logic [3:0] ien_wdata;
  logic       inta;
  logic       eoi;

  int checks = 0;
  int errors = 0;

  intr_if #(.NSRC(4), .IDW(2)) bus0 ();
  intr_if #(.NSRC(4), .IDW(2)) bus1 ();

  assign bus0.irq = irq;   assign bus0.ien_we = ien_we; assign bus0.ien_wdata = ien_wdata;
  assign bus0.inta = inta; assign bus0.eoi = eoi;
  assign bus1.irq = irq;   assign bus1.ien_we = ien_we; assign bus1.ien_wdata = ien_wdata;
  assign bus1.inta = inta; assign bus1.eoi = eoi;

  intr_ctrl #(.NSRC(4), .IDW(2), .RR(0)) dut0 (.clk(clk), .clrn(clrn), .bus(bus0));
  intr_ctrl #(.NSRC(4), .IDW(2), .RR(1)) dut1 (.clk(clk), .clrn(clrn), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: index 0 = fixed priority, index 1 = round-robin.
  logic [3:0] m_pend [2];
  logic [3:0] m_prev [2];
  logic [3:0] m_ien  [2];
  logic       m_intr [2];
  logic       m_busy [2];
  int         m_id   [2];
  int         m_ptr  [2];

  task automatic model_edge(input int r);
    logic [3:0] set_b, elig, clr_b;
    int start, idx;
    if (!clrn) begin
      m_pend[r] = 4'b0; m_prev[r] = 4'b0; m_ien[r] = 4'b1111;
      m_intr[r] = 1'b0; m_busy[r] = 1'b0; m_id[r] = 0; m_ptr[r] = 0;
    end else begin
      set_b = irq & ~m_prev[r];
      elig  = m_pend[r] & m_ien[r];
      clr_b = 4'b0;
      if (m_intr[r]) begin
        if (inta) begin
          m_intr[r] = 1'b0; m_busy[r] = 1'b1; clr_b = 4'b0001 << m_id[r];
        end
      end else if (m_busy[r]) begin
        if (eoi) begin
          m_busy[r] = 1'b0;
          if (r == 1) m_ptr[r] = (m_id[r] + 1) % 4;
        end
      end else if (elig != 4'b0) begin
        start = (r == 1) ? m_ptr[r] : 0;
        for (int k = 0; k < 4; k++) begin
          idx = (start + k) % 4;
          if (((elig >> idx) & 4'b0001) != 4'b0) begin
            m_id[r] = idx;
            break;
          end
        end
        m_intr[r] = 1'b1;
      end
      m_pend[r] = (m_pend[r] & ~clr_b) | set_b;
      m_prev[r] = irq;
      if (ien_we) m_ien[r] = ien_wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " dut0.intr"},    32'(bus0.intr),    32'(m_intr[0]));
    chk({tag, " dut0.busy"},    32'(bus0.busy),    32'(m_busy[0]));
    chk({tag, " dut0.pending"}, 32'(bus0.pending), 32'(m_pend[0]));
    chk({tag, " dut0.ien"},     32'(bus0.ien),     32'(m_ien[0]));
    chk({tag, " dut0.irq_id"},  32'(bus0.irq_id),  32'(m_id[0]));
    chk({tag, " dut1.intr"},    32'(bus1.intr),    32'(m_intr[1]));
    chk({tag, " dut1.busy"},    32'(bus1.busy),    32'(m_busy[1]));
    chk({tag, " dut1.pending"}, 32'(bus1.pending), 32'(m_pend[1]));
    chk({tag, " dut1.ien"},     32'(bus1.ien),     32'(m_ien[1]));
    chk({tag, " dut1.irq_id"},  32'(bus1.irq_id),  32'(m_id[1]));
  endtask

  typedef struct {
    logic       clrn;
    logic [3:0] irq;
    logic       inta;
    logic       eoi;
    logic       we;
    logic [3:0] wd;
    logic       x_intr;
    logic       x_busy;
    logic [3:0] x_pend;
    logic [3:0] x_ien;
    logic [1:0] x_id;
  } vec_t;

  vec_t tbl [27];
  int   exp_rr [4];
  int   waited;

  initial begin
    clrn = 1'b0; irq = 4'b0; ien_we = 1'b0; ien_wdata = 4'b0; inta = 1'b0; eoi = 1'b0;

    // clrn irq inta eoi we wd | intr busy pend ien id
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0};
    tbl[2]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b1111, 2'd0};
    tbl[3]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b1111, 2'd2};
    tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b1111, 2'd2};
    tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1111, 2'd2};
    tbl[6]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd2};
    tbl[7]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1111, 2'd2};
    tbl[8]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1010, 4'b1111, 2'd1};
    tbl[9]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b1111, 2'd1};
    tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b1111, 2'd1};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 4'b1111, 2'd3};
    tbl[12] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1111, 2'd3};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd3};
    tbl[14] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 4'b0000, 4'b1110, 2'd3};
    tbl[15] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1110, 2'd3};
    tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1110, 2'd3};
    tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1110, 2'd3};
    tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 4'b1111, 2'd3};
    tbl[19] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b1111, 2'd0};
    tbl[20] = '{1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b1111, 2'd0};
    tbl[21] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1111, 2'd0};
    tbl[22] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b1111, 2'd0};
    tbl[23] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1111, 2'd0};
    tbl[24] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1111, 2'd0};
    tbl[25] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0};
    tbl[26] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0};

    for (int r = 0; r < 27; r++) begin
      clrn = tbl[r].clrn; irq = tbl[r].irq; inta = tbl[r].inta; eoi = tbl[r].eoi;
      ien_we = tbl[r].we; ien_wdata = tbl[r].wd;
      tick();
      chk($sformatf("vec%0d intr", r),    32'(bus0.intr),    32'(tbl[r].x_intr));
      chk($sformatf("vec%0d busy", r),    32'(bus0.busy),    32'(tbl[r].x_busy));
      chk($sformatf("vec%0d pending", r), 32'(bus0.pending), 32'(tbl[r].x_pend));
      chk($sformatf("vec%0d ien", r),     32'(bus0.ien),     32'(tbl[r].x_ien));
      chk($sformatf("vec%0d irq_id", r),  32'(bus0.irq_id),  32'(tbl[r].x_id));
      cmp_model($sformatf("vec%0d model", r));
    end
    inta = 1'b0; eoi = 1'b0; ien_we = 1'b0;

    // Round-robin: sources 0 and 1 re-pulsed during every service.
    exp_rr = '{0, 1, 0, 1};
    clrn = 1'b0; irq = 4'b0; tick();
    clrn = 1'b1; irq = 4'b0011; tick();
    irq = 4'b0000; tick();
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (!bus1.intr && waited < 6) begin
        tick();
        waited++;
      end
      chk($sformatf("rr grant%0d intr", g), 32'(bus1.intr), 32'd1);
      chk($sformatf("rr grant%0d irq_id", g), 32'(bus1.irq_id), 32'(exp_rr[g]));
      inta = 1'b1; tick(); inta = 1'b0;
      irq = 4'b0011; tick();
      irq = 4'b0000; tick();
      eoi = 1'b1; tick(); eoi = 1'b0;
      cmp_model($sformatf("rr%0d model", g));
    end

    // Reset while a service is in flight; a stale eoi afterwards must do nothing.
    clrn = 1'b0; tick();
    clrn = 1'b1; irq = 4'b0100; tick();
    irq = 4'b0000; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    chk("midrst busy before", 32'(bus0.busy), 32'd1);
    clrn = 1'b0; tick();
    chk("midrst intr",    32'(bus0.intr),    32'd0);
    chk("midrst busy",    32'(bus0.busy),    32'd0);
    chk("midrst pending", 32'(bus0.pending), 32'd0);
    clrn = 1'b1; eoi = 1'b1; tick(); eoi = 1'b0;
    chk("midrst eoi busy", 32'(bus0.busy), 32'd0);
    chk("midrst eoi intr", 32'(bus0.intr), 32'd0);
    tick();
    chk("midrst idle intr", 32'(bus0.intr), 32'd0);
    cmp_model("midrst model");

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      clrn      = ($urandom_range(63) != 0);
      irq       = 4'($urandom);
      inta      = ($urandom_range(3) == 0);
      eoi       = ($urandom_range(3) == 0);
      ien_we    = ($urandom_range(15) == 0);
      ien_wdata = 4'($urandom);
      tick();
      cmp_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
